// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES block types, arbiter states and known-answer vector
// Imported by the decrypt arbiter and its round-robin selector.
package des_pkg;

  localparam int DES_BLOCK_W = 64;

  typedef logic [DES_BLOCK_W-1:0] des_block_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } arb_state_e;

  localparam des_block_t KAT_KEY    = 64'h1334_5779_9BBC_DFF1;
  localparam des_block_t KAT_CIPHER = 64'h85E8_1354_0F0A_B405;
  localparam des_block_t KAT_PLAIN  = 64'h0123_4567_89AB_CDEF;

endpackage

// File: rtl/des_rr_arbiter.sv
// rtl/des_rr_arbiter.sv - combinational round-robin winner select
// Searches req from last+1 upward, wrapping; grant is one-hot and gated by enable.
module des_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             w_hit;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    grant = '0;
    index = '0;
    w_hit = 1'b0;
    w_pos = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_pos = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!w_hit && req[w_pos]) begin
        w_hit        = 1'b1;
        index        = w_pos;
        grant[w_pos] = enable;
      end
    end
  end

endmodule

// File: rtl/des_dec_arbiter.sv
// rtl/des_dec_arbiter.sv - round-robin share of one pipelined DES decrypt core
// Optional per-requester grant counters under DES_ARB_PERF_EN.
module des_dec_arbiter
  import des_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CORE_LAT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DES_BLOCK_W-1:0] req_key,
  input  logic [NUM_REQ*DES_BLOCK_W-1:0] req_cipher,
  output des_block_t                     core_key,
  output des_block_t                     core_cipher,
  input  des_block_t                     core_decrypt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output des_block_t                     rsp_data,
  input  logic                           quiesce_req,
  output logic                           quiesce_ack,
  output logic [NUM_REQ*16-1:0]          perf_grants
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CORE_LAT + 2);

  arb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_rr_last, w_win_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_enable, w_accept, w_retire;
  logic [CORE_LAT:0]  r_tag_vld;
  logic [IDX_W-1:0]   r_tag_idx [CORE_LAT+1];
  logic [CNT_W-1:0]   r_inflight;
  des_block_t         r_core_key, r_core_cipher, r_rsp_data;
  des_block_t         w_sel_key, w_sel_cipher;
  logic [NUM_REQ-1:0] r_rsp_valid;

  assign w_enable  = (r_state == RUN) && !quiesce_req;
  assign w_accept  = |(req_valid & w_grant);
  assign w_retire  = r_tag_vld[CORE_LAT];
  assign req_ready = w_grant;

  assign core_key    = r_core_key;
  assign core_cipher = r_core_cipher;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;

  des_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid),
    .last   (r_rr_last),
    .enable (w_enable),
    .grant  (w_grant),
    .index  (w_win_idx)
  );

  always_comb begin
    w_sel_key    = '0;
    w_sel_cipher = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_sel_key    = req_key[i*DES_BLOCK_W +: DES_BLOCK_W];
        w_sel_cipher = req_cipher[i*DES_BLOCK_W +: DES_BLOCK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last     <= IDX_W'(NUM_REQ - 1);
      r_tag_vld     <= '0;
      r_inflight    <= '0;
      r_core_key    <= '0;
      r_core_cipher <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[CORE_LAT-1:0], w_accept};
      r_rsp_valid <= '0;
      if (w_retire) begin
        r_rsp_valid[r_tag_idx[CORE_LAT]] <= 1'b1;
        r_rsp_data                       <= core_decrypt;
      end
      if (w_accept) begin
        r_rr_last     <= w_win_idx;
        r_core_key    <= w_sel_key;
        r_core_cipher <= w_sel_cipher;
      end
      case ({w_accept, w_retire})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Owner indices travel alongside the valid bits; only the valid bits need reset.
  always_ff @(posedge clk) begin
    r_tag_idx[0] <= w_win_idx;
    for (int k = 1; k <= CORE_LAT; k++) begin
      r_tag_idx[k] <= r_tag_idx[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    quiesce_ack = 1'b0;
    case (r_state)
      RUN: begin
        if (quiesce_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!quiesce_req)            w_state_nxt = RUN;
        else if (r_inflight == '0)   w_state_nxt = HELD;
      end
      HELD: begin
        quiesce_ack = 1'b1;
        if (!quiesce_req) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

`ifdef DES_ARB_PERF_EN
  logic [15:0] r_perf [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        r_perf[i] <= '0;
      end else if (req_valid[i] && w_grant[i] && (r_perf[i] != 16'hFFFF)) begin
        r_perf[i] <= r_perf[i] + 16'd1;
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      perf_grants[i*16 +: 16] = r_perf[i];
    end
  end
`else
  assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_des_dec_arbiter.sv
// tb/tb_des_dec_arbiter.sv - directed vector bench for des_dec_arbiter
// Includes a stand-in core: fixed-latency pipe returning the KAT plaintext or key^cipher.
module tb_des_dec_arbiter;
  import des_pkg::*;

  localparam int NUM_REQ  = 2;
  localparam int CORE_LAT = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*64-1:0]  req_key = '0;
  logic [NUM_REQ*64-1:0]  req_cipher = '0;
  des_block_t             core_key, core_cipher, core_decrypt;
  logic [NUM_REQ-1:0]     rsp_valid;
  des_block_t             rsp_data;
  logic                   quiesce_req = 1'b0;
  logic                   quiesce_ack;
  logic [NUM_REQ*16-1:0]  perf_grants;

  always #5 clk = ~clk;

  des_dec_arbiter #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_cipher   (req_cipher),
    .core_key     (core_key),
    .core_cipher  (core_cipher),
    .core_decrypt (core_decrypt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .quiesce_req  (quiesce_req),
    .quiesce_ack  (quiesce_ack),
    .perf_grants  (perf_grants)
  );

  des_block_t core_pipe [CORE_LAT];

  function automatic des_block_t core_f(input des_block_t k, input des_block_t c);
    if (k == KAT_KEY && c == KAT_CIPHER) return KAT_PLAIN;
    return k ^ c;
  endfunction

  always @(posedge clk) begin
    core_pipe[0] <= core_f(core_key, core_cipher);
    for (int k = 1; k < CORE_LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign core_decrypt = core_pipe[CORE_LAT-1];

  typedef struct {
    logic [1:0]  valid;
    des_block_t  k0, c0, k1, c1;
    logic [1:0]  ready;
    logic [1:0]  rsp;
    des_block_t  data;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_keys(input des_block_t k0, input des_block_t c0,
                          input des_block_t k1, input des_block_t c1);
    req_key    = {k1, k0};
    req_cipher = {c1, c0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; quiesce_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic des_block_t blk(input int r, input int s);
    return {32'(r), 32'(s)};
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    vec_t       tbl [8];
    logic       early;
    logic [1:0] exp_m, exp_r;

    tbl[0] = '{2'b01, KAT_KEY, KAT_CIPHER, 64'h0, 64'h0, 2'b01, 2'b01, KAT_PLAIN};
    tbl[1] = '{2'b11, 64'h1111111111111111, 64'h2222222222222222,
               64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 2'b10, 2'b10, 64'hF0F00F0FF0F00F0F};
    tbl[2] = '{2'b11, 64'h1111111111111111, 64'h2222222222222222,
               64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 2'b01, 2'b01, 64'h3333333333333333};
    tbl[3] = '{2'b01, 64'hAAAAAAAA55555555, 64'h5555555555555555,
               64'h0, 64'h0, 2'b01, 2'b01, 64'hFFFFFFFF00000000};
    tbl[4] = '{2'b10, 64'h0, 64'h0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2'b10, 2'b10, 64'h0};
    tbl[5] = '{2'b10, 64'h0, 64'h0, 64'h8000000000000001, 64'h0, 2'b10, 2'b10, 64'h8000000000000001};
    tbl[6] = '{2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 2'b00, 64'h0};
    tbl[7] = '{2'b11, 64'hDEADBEEF00000000, 64'h00000000DEADBEEF,
               64'h0, 64'h0, 2'b01, 2'b01, 64'hDEADBEEFDEADBEEF};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_core_key", core_key, 64'h0);
    chk("rst_core_cipher", core_cipher, 64'h0);
    chk("rst_ack", 64'(quiesce_ack), 64'h0);

    // Single-block vectors, each run to completion
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid;
      set_keys(tbl[v].k0, tbl[v].c0, tbl[v].k1, tbl[v].c1);
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(tbl[v].ready));
      @(negedge clk);
      req_valid = '0;
      early = |rsp_valid;
      repeat (16) begin
        @(negedge clk);
        early = early | (|rsp_valid);
      end
      chk($sformatf("vec%0d_early_rsp", v), 64'(early), 64'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_rsp_valid", v), 64'(rsp_valid), 64'(tbl[v].rsp));
      if (tbl[v].rsp != 2'b00) chk($sformatf("vec%0d_rsp_data", v), rsp_data, tbl[v].data);
    end

    // Fairness: both requesters held valid for 8 accepts
    do_reset();
    for (int n = 0; n < 28; n++) begin
      @(negedge clk);
      if (n < 8) begin
        req_valid = 2'b11;
        set_keys(blk(0, (n + 1) & ~1), '0, blk(1, n | 1), '0);
      end else begin
        req_valid = '0;
      end
      #1;
      if (n < 8) chk($sformatf("fair_ready_%0d", n), 64'(req_ready), 64'(onehot(n % 2)));
      exp_m = (n >= 18 && n < 26) ? onehot((n - 18) % 2) : 2'b00;
      chk($sformatf("fair_rsp_%0d", n), 64'(rsp_valid), 64'(exp_m));
      if (exp_m != 2'b00) chk($sformatf("fair_data_%0d", n), rsp_data, blk((n - 18) % 2, n - 18));
    end

    // Quiesce with 5 blocks in flight, then resume
    for (int n = 0; n < 47; n++) begin
      @(negedge clk);
      if (n <= 5) begin
        req_valid = 2'b11;
        set_keys(blk(0, (n + 1) & ~1), '0, blk(1, n | 1), '0);
      end
      if (n == 5)  quiesce_req = 1'b1;
      if (n == 25) quiesce_req = 1'b0;
      if (n == 27) req_valid = '0;
      #1;
      exp_r = (n < 5) ? onehot(n % 2) : ((n == 26) ? 2'b10 : 2'b00);
      chk($sformatf("qsc_ready_%0d", n), 64'(req_ready), 64'(exp_r));
      exp_m = (n >= 18 && n <= 22) ? onehot((n - 18) % 2) : ((n == 44) ? 2'b10 : 2'b00);
      chk($sformatf("qsc_rsp_%0d", n), 64'(rsp_valid), 64'(exp_m));
      if (n >= 18 && n <= 22) chk($sformatf("qsc_data_%0d", n), rsp_data, blk((n - 18) % 2, n - 18));
      if (n == 44) chk("qsc_resume_data", rsp_data, blk(1, 5));
      chk($sformatf("qsc_ack_%0d", n), 64'(quiesce_ack), (n >= 23 && n <= 25) ? 64'h1 : 64'h0);
    end

    // Steady single requester: one block per cycle, in-flight pinned at 17
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (n < 30) begin
        req_valid = 2'b01;
        set_keys(blk(0, n), '0, '0, '0);
      end else begin
        req_valid = '0;
      end
      #1;
      if (n < 30) chk($sformatf("stdy_ready_%0d", n), 64'(req_ready), 64'h1);
      if (n >= 17 && n < 30) chk($sformatf("stdy_inflight_%0d", n), 64'(dut.r_inflight), 64'd17);
      exp_m = (n >= 18 && n < 48) ? 2'b01 : 2'b00;
      chk($sformatf("stdy_rsp_%0d", n), 64'(rsp_valid), 64'(exp_m));
      if (exp_m != 2'b00) chk($sformatf("stdy_data_%0d", n), rsp_data, blk(0, n - 18));
    end
`ifndef DES_ARB_PERF_EN
    chk("perf_off_after_stream", 64'(perf_grants), 64'h0);
`endif

    // Reset with 3 blocks in flight; pointer left on req0 beforehand
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      if (n < 2) req_valid = 2'b11;
      if (n == 2) req_valid = 2'b01;
      if (n < 3) set_keys(blk(0, 100 + n), 64'h55, blk(1, 200 + n), 64'hAA);
      if (n == 3) begin
        req_valid = '0;
        reset = 1'b1;
      end
      if (n == 4) reset = 1'b0;
      if (n == 25) req_valid = 2'b11;
      #1;
      if (n == 4) begin
        chk("rmid_ready", 64'(req_ready), 64'h0);
        chk("rmid_rsp_data", rsp_data, 64'h0);
        chk("rmid_core_key", core_key, 64'h0);
        chk("rmid_core_cipher", core_cipher, 64'h0);
        chk("rmid_ack", 64'(quiesce_ack), 64'h0);
      end
      if (n >= 4) chk($sformatf("rmid_rsp_%0d", n), 64'(rsp_valid), 64'h0);
      if (n == 25) chk("rmid_first_grant", 64'(req_ready), 64'h1);
    end
    @(negedge clk);
    req_valid = '0;

`ifdef DES_ARB_PERF_EN
    do_reset();
    #1;
    chk("perf_reset", 64'(perf_grants), 64'h0);
    @(negedge clk);
    req_valid = 2'b10;
    repeat (70000) @(negedge clk);
    req_valid = '0;
    #1;
    chk("perf_req1_sat", 64'(perf_grants[31:16]), 64'hFFFF);
    chk("perf_req0_idle", 64'(perf_grants[15:0]), 64'h0);
`else
    chk("perf_off_end", 64'(perf_grants), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
